hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard sources in, pipeline-register stall/flush enables out.
// The pipeline uses the master modport and the controller uses the slave modport.
interface hazard_ctrl_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic [4:0] ex_rd;
   logic       ex_memtoreg;
   logic       ex_reg_en;
   logic       ex_br_taken;
   logic       mem_busy;
   logic       pc_stall;
   logic       if_id_stall;
   logic       if_id_flush;
   logic       id_ex_stall;
   logic       id_ex_flush;
   logic       ex_mem_stall;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memtoreg, ex_reg_en,
             ex_br_taken, mem_busy,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memtoreg, ex_reg_en,
             ex_br_taken, mem_busy,
      output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller for the 5-stage core: load-use bubbles, branch flushes,
// data-memory freeze, plus saturating stall/flush event counters.
module hazard_ctrl #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned BR_PENALTY = 2
) (
   input  logic             clock,
   input  logic             reset,
   hazard_ctrl_if.slave     hz,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t     cur, nxt;
   logic [3:0] flush_left, flush_left_nxt;
   logic       lu;
   logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;

   // x0 can never carry a hazard, so rd==0 masks the compare
   always_comb begin
      lu = hz.ex_memtoreg & hz.ex_reg_en & (hz.ex_rd != 5'd0) &
           ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
            (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cur        <= RUN;
         flush_left <= '0;
      end else begin
         cur        <= nxt;
         flush_left <= flush_left_nxt;
      end
   end

   always_comb begin
      nxt            = cur;
      flush_left_nxt = flush_left;
      pc_stall       = 1'b0;
      if_id_stall    = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_stall    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_stall   = 1'b0;
      if (hz.mem_busy) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         nxt          = (cur == FLUSH) ? FLUSH : MEM_WAIT;
      end else if (cur == FLUSH) begin
         // EX holds a bubble here, so branch and load-use inputs are irrelevant
         if_id_flush    = 1'b1;
         flush_left_nxt = flush_left - 4'd1;
         nxt            = (flush_left <= 4'd1) ? RUN : FLUSH;
      end else begin
         // RUN and a released MEM_WAIT share the same decision in the same cycle
         nxt = RUN;
         if (hz.ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (BR_PENALTY > 1) begin
               nxt            = FLUSH;
               flush_left_nxt = 4'(BR_PENALTY - 1);
            end
         end else if (lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if ((if_id_flush || id_ex_flush) && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign state           = cur;
   assign hz.pc_stall     = pc_stall;
   assign hz.if_id_stall  = if_id_stall;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.id_ex_stall  = id_ex_stall;
   assign hz.id_ex_flush  = id_ex_flush;
   assign hz.ex_mem_stall = ex_mem_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (BR_PENALTY 2/3, CNT_W 16/4) share one
// stimulus stream; expected outputs are queued at drive time and compared at the falling edge.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mtr;
      logic       ren;
      logic       br;
      logic       busy;
   } stim_t;

   typedef struct {
      string       tag;
      int unsigned dut;
      logic [7:0]  ctrl;
   } exp_t;

   // output bit order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
   localparam logic [5:0] O_IDLE = 6'b000000;
   localparam logic [5:0] O_FRZ  = 6'b110101;
   localparam logic [5:0] O_BR   = 6'b001010;
   localparam logic [5:0] O_LU   = 6'b110010;
   localparam logic [5:0] O_FL   = 6'b001000;

   logic        clock = 1'b0;
   logic        reset;
   stim_t       s;
   logic [1:0]  st [3];
   logic [5:0]  o6 [3];
   logic [15:0] sc0, fc0, sc1, fc1;
   logic [3:0]  sc2, fc2;

   exp_t        q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned es [3];
   int unsigned ef [3];

   always #5 clock = ~clock;

   hazard_ctrl_if hif [3] ();

   assign reset = s.rst;

   for (genvar g = 0; g < 3; g++) begin : g_drv
      always_comb begin
         hif[g].id_rs1      = s.rs1;
         hif[g].id_rs2      = s.rs2;
         hif[g].id_use_rs1  = s.u1;
         hif[g].id_use_rs2  = s.u2;
         hif[g].ex_rd       = s.rd;
         hif[g].ex_memtoreg = s.mtr;
         hif[g].ex_reg_en   = s.ren;
         hif[g].ex_br_taken = s.br;
         hif[g].mem_busy    = s.busy;
      end
      assign o6[g] = {hif[g].pc_stall, hif[g].if_id_stall, hif[g].if_id_flush,
                      hif[g].id_ex_stall, hif[g].id_ex_flush, hif[g].ex_mem_stall};
   end

   hazard_ctrl #(.CNT_W(16), .BR_PENALTY(2)) u0 (
      .clock(clock), .reset(reset), .hz(hif[0]), .state(st[0]), .stall_cnt(sc0), .flush_cnt(fc0));
   hazard_ctrl #(.CNT_W(16), .BR_PENALTY(3)) u1 (
      .clock(clock), .reset(reset), .hz(hif[1]), .state(st[1]), .stall_cnt(sc1), .flush_cnt(fc1));
   hazard_ctrl #(.CNT_W(4), .BR_PENALTY(2)) u2 (
      .clock(clock), .reset(reset), .hz(hif[2]), .state(st[2]), .stall_cnt(sc2), .flush_cnt(fc2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic stim_t st_idle();
      st_idle = '0;
   endfunction

   function automatic stim_t st_rst();
      st_rst = '0;
      st_rst.rst = 1'b1;
   endfunction

   function automatic stim_t st_lu();
      st_lu = '0;
      st_lu.mtr = 1'b1;
      st_lu.ren = 1'b1;
      st_lu.rd  = 5'd5;
      st_lu.u2  = 1'b1;
      st_lu.rs2 = 5'd5;
   endfunction

   function automatic stim_t st_br();
      st_br = '0;
      st_br.br = 1'b1;
   endfunction

   function automatic stim_t st_busy();
      st_busy = '0;
      st_busy.busy = 1'b1;
   endfunction

   // called at posedge+1; checks at the next falling edge and returns at posedge+1
   task automatic step(input stim_t stim, input logic [7:0] e0, input logic [7:0] e1, input bit chk);
      exp_t e;
      logic [7:0] act;
      s = stim;
      if (chk) begin
         q.push_back('{"ctrl_br2", 0, e0});
         q.push_back('{"ctrl_br3", 1, e1});
         q.push_back('{"ctrl_cnt4", 2, e0});
      end
      @(negedge clock);
      if (chk) begin
         check("stall_cnt_u0", 32'(sc0), es[0]);
         check("flush_cnt_u0", 32'(fc0), ef[0]);
         check("stall_cnt_u1", 32'(sc1), es[1]);
         check("flush_cnt_u1", 32'(fc1), ef[1]);
         check("stall_cnt_u2", 32'(sc2), es[2]);
         check("flush_cnt_u2", 32'(fc2), ef[2]);
      end
      while (q.size() > 0) begin
         e   = q.pop_front();
         act = {st[e.dut], o6[e.dut]};
         check(e.tag, 32'(act), 32'(e.ctrl));
      end
      if (stim.rst) begin
         for (int i = 0; i < 3; i++) begin
            es[i] = 0;
            ef[i] = 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            logic [7:0] ee;
            int unsigned lim;
            ee  = (i == 1) ? e1 : e0;
            lim = (i == 2) ? 15 : 65535;
            if (ee[5] && es[i] < lim) es[i]++;
            if ((ee[3] || ee[1]) && ef[i] < lim) ef[i]++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      stim_t t;
      s = st_rst();
      @(posedge clock);
      #1;
      step(st_rst(), '0, '0, 1'b0);
      step(st_rst(), '0, '0, 1'b0);
      step(st_idle(), {2'd0, O_IDLE}, {2'd0, O_IDLE}, 1'b1);

      // single load-use bubble, then EX carries rd=0
      step(st_lu(), {2'd0, O_LU}, {2'd0, O_LU}, 1'b1);
      t = st_lu();
      t.rd = 5'd0;
      step(t, {2'd0, O_IDLE}, {2'd0, O_IDLE}, 1'b1);
      check("lu_stall_cnt", 32'(sc0), 32'd1);
      check("lu_flush_cnt", 32'(fc0), 32'd1);

      // x0 destination and non-writing load are not hazards
      t = '0;
      t.mtr = 1'b1; t.ren = 1'b1; t.rd = 5'd0; t.u1 = 1'b1; t.rs1 = 5'd0;
      step(t, {2'd0, O_IDLE}, {2'd0, O_IDLE}, 1'b1);
      t = st_lu();
      t.ren = 1'b0;
      step(t, {2'd0, O_IDLE}, {2'd0, O_IDLE}, 1'b1);

      // taken branch, penalty 2 vs 3
      step(st_br(),   {2'd0, O_BR},   {2'd0, O_BR},   1'b1);
      step(st_idle(), {2'd1, O_FL},   {2'd1, O_FL},   1'b1);
      step(st_idle(), {2'd0, O_IDLE}, {2'd1, O_FL},   1'b1);
      step(st_idle(), {2'd0, O_IDLE}, {2'd0, O_IDLE}, 1'b1);
      check("br_flush_cnt", 32'(fc0), 32'd3);

      // freeze beats both branch and load-use; release applies the branch
      t = st_lu();
      t.br = 1'b1;
      t.busy = 1'b1;
      step(t, {2'd0, O_FRZ}, {2'd0, O_FRZ}, 1'b1);
      step(t, {2'd2, O_FRZ}, {2'd2, O_FRZ}, 1'b1);
      step(t, {2'd2, O_FRZ}, {2'd2, O_FRZ}, 1'b1);
      t.busy = 1'b0;
      step(t,         {2'd2, O_BR},   {2'd2, O_BR},   1'b1);
      step(st_idle(), {2'd1, O_FL},   {2'd1, O_FL},   1'b1);
      step(st_idle(), {2'd0, O_IDLE}, {2'd1, O_FL},   1'b1);
      step(st_idle(), {2'd0, O_IDLE}, {2'd0, O_IDLE}, 1'b1);
      check("frz_stall_cnt", 32'(sc0), 32'd4);

      // memory stall during FLUSH holds flush_left
      step(st_br(),   {2'd0, O_BR},   {2'd0, O_BR},   1'b1);
      step(st_busy(), {2'd1, O_FRZ},  {2'd1, O_FRZ},  1'b1);
      step(st_busy(), {2'd1, O_FRZ},  {2'd1, O_FRZ},  1'b1);
      step(st_idle(), {2'd1, O_FL},   {2'd1, O_FL},   1'b1);
      step(st_idle(), {2'd0, O_IDLE}, {2'd1, O_FL},   1'b1);
      step(st_idle(), {2'd0, O_IDLE}, {2'd0, O_IDLE}, 1'b1);

      // reset while in FLUSH
      step(st_br(),   {2'd0, O_BR},   {2'd0, O_BR},   1'b1);
      step(st_rst(),  '0, '0, 1'b0);
      step(st_idle(), {2'd0, O_IDLE}, {2'd0, O_IDLE}, 1'b1);

      // 20 stall cycles: narrow counter must pin at 15
      for (int i = 0; i < 10; i++)
         step(st_lu(), {2'd0, O_LU}, {2'd0, O_LU}, 1'b1);
      step(st_busy(), {2'd0, O_FRZ}, {2'd0, O_FRZ}, 1'b1);
      for (int i = 0; i < 9; i++)
         step(st_busy(), {2'd2, O_FRZ}, {2'd2, O_FRZ}, 1'b1);
      step(st_idle(), {2'd2, O_IDLE}, {2'd2, O_IDLE}, 1'b1);
      step(st_idle(), {2'd0, O_IDLE}, {2'd0, O_IDLE}, 1'b1);
      check("sat_stall_cnt4", 32'(sc2), 32'd15);
      check("sat_stall_cnt16", 32'(sc0), 32'd20);
      check("sat_flush_cnt4", 32'(fc2), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
